// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, serial-adder state type and counter sizing.
package alu_pkg;
  localparam int ALU_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder on one full_adder; SERIAL_ADDER_SUB_EN adds sub/overflow.
module serial_adder import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub,
  output logic             overflow
`endif
);
  localparam int CW = cnt_w(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
  logic sub_q, sub_d, sub_in, fa_sum, fa_cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic ovf_q, ovf_d;
  assign sub_in   = sub;
  assign overflow = ovf_q;
`else
  assign sub_in = 1'b0;
`endif
  full_adder u_fa (
    .a (a_q[0]),
    .b (b_q[0] ^ sub_q),
    .ci(carry_q),
    .s (fa_sum),
    .co(fa_cout)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == SHIFT) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      s_d     = WIDTH'({fa_sum, s_q} >> 1);
      carry_d = fa_cout;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        sum_d   = s_d;
        cout_d  = fa_cout;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        // carry_q is the carry into the MSB on the final bit
        ovf_d   = carry_q ^ fa_cout;
`endif
      end
    end else if (start) begin
      state_d = SHIFT;
      a_d     = a;
      b_d     = b;
      s_d     = '0;
      sub_d   = sub_in;
      carry_d = sub_in | cin;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against an arithmetic model.
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, start, cin, sub_i, busy, done, cout;
  logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic ovf;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub_i), .overflow(ovf)
`endif
  );

  // returns {overflow, cout, sum} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] x, y, input logic c, s);
    int ux, uy, sx, sy, t, r;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 2**(W-1)) ? ux - 2**W : ux;
    sy = (uy >= 2**(W-1)) ? uy - 2**W : uy;
    t = s ? ux + (2**W - 1 - uy) + 1 : ux + uy + int'(c);
    r = s ? sx - sy : sx + sy + int'(c);
    return {(r < -(2**(W-1))) || (r >= 2**(W-1)), t >= 2**W, t[W-1:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] x, y, input logic c, s);
    start = 1'b1; a = x; b = y; cin = c; sub_i = s;
    tick;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_i = 1'($urandom);
  endtask

  task automatic wait_done(output int lat, output int busy_n, output bit changed);
    logic [W-1:0] s0;
    s0 = sum; lat = 1; busy_n = 0; changed = 0;
    while (done !== 1'b1 && lat < 40) begin
      busy_n += int'(busy);
      if (sum !== s0) changed = 1;
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef SERIAL_ADDER_SUB_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [3], tb [3], es [3];
    logic tc [3], ec [3];
    int lat, bn;
    bit ch;
    ta = '{8'h0F, 8'hFF, 8'hFF}; tb = '{8'h01, 8'h01, 8'hFF}; tc = '{1'b0, 1'b0, 1'b1};
    es = '{8'h10, 8'h00, 8'hFF}; ec = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      launch(ta[i], tb[i], tc[i], 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dir_busy1[%0d]: got %b want 1", i, busy); end
      wait_done(lat, bn, ch);
      checks++; if (lat !== 9) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want 9", i, lat); end
      checks++; if (bn !== 8) begin errors++; $display("FAIL dir_busy_cycles[%0d]: got %0d want 8", i, bn); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir_busy_at_done[%0d]: got %b want 0", i, busy); end
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL dir_sum[%0d]: got %h want %h", i, sum, es[i]); end
      checks++; if (cout !== ec[i]) begin errors++; $display("FAIL dir_cout[%0d]: got %b want %b", i, cout, ec[i]); end
      tick;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir_done_pulse[%0d]: got %b want 0", i, done); end
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL dir_sum_hold[%0d]: got %h want %h", i, sum, es[i]); end
      repeat (2) tick;
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] x, y;
    logic c, s;
    logic [W+1:0] e;
    int lat, bn;
    bit ch;
    launch(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done(lat, bn, ch);
    checks++; if (sum !== 8'hFF) begin errors++; $display("FAIL b2b_first_sum: got %h want ff", sum); end
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(lat, bn, ch);
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency: got %0d want 9", lat); end
    checks++; if (ch !== 1'b0) begin errors++; $display("FAIL b2b_prior_held: result changed before done"); end
    checks++; if (sum !== 8'h46) begin errors++; $display("FAIL b2b_sum: got %h want 46", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL b2b_cout: got %b want 0", cout); end
    for (int i = 0; i < 8; i++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom); s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`endif
      e = model(x, y, c, s);
      launch(x, y, c, s);
      wait_done(lat, bn, ch);
      checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_chain_lat[%0d]: got %0d want 9", i, lat); end
      checks++; if ({cout, sum} !== e[W:0]) begin errors++; $display("FAIL b2b_chain_res[%0d]: got %b_%h want %b_%h", i, cout, sum, e[W], e[W-1:0]); end
    end
    tick;
  endtask

  task automatic test_ignore_start;
    logic [W-1:0] x, y;
    logic c;
    logic [W+1:0] e;
    int lat, bn, n;
    bit ch;
    x = W'($urandom); y = W'($urandom); c = 1'($urandom);
    e = model(x, y, c, 1'b0);
    launch(x, y, c, 1'b0);
    tick; tick;
    start = 1'b1; a = ~x; b = y ^ 8'h5A; cin = ~c;
    tick;
    start = 1'b0;
    wait_done(lat, bn, ch);
    checks++; if (lat + 3 !== 9) begin errors++; $display("FAIL ign_latency: got %0d want 9", lat + 3); end
    checks++; if ({cout, sum} !== e[W:0]) begin errors++; $display("FAIL ign_result: got %b_%h want %b_%h", cout, sum, e[W], e[W-1:0]); end
    n = 0;
    repeat (12) begin tick; n += int'(done); end
    checks++; if (n !== 0) begin errors++; $display("FAIL ign_extra_done: got %0d want 0", n); end
  endtask

  task automatic test_reset_mid;
    int lat, bn, n;
    bit ch;
    launch(8'h0F, 8'h01, 1'b0, 1'b0);
    wait_done(lat, bn, ch);
    launch(W'($urandom), W'($urandom), 1'b1, 1'b0);
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rmid_sum: got %h want 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rmid_cout: got %b want 0", cout); end
    n = 0;
    repeat (12) begin n += int'(done) + int'(busy); tick; end
    checks++; if (n !== 0) begin errors++; $display("FAIL rmid_activity: got %0d want 0", n); end
    launch(8'h80, 8'h80, 1'b0, 1'b0);
    wait_done(lat, bn, ch);
    checks++; if (lat !== 9) begin errors++; $display("FAIL rmid_next_lat: got %0d want 9", lat); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rmid_next_sum: got %h want 00", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL rmid_next_cout: got %b want 1", cout); end
    tick;
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    logic c, s;
    logic [W+1:0] e;
    int lat, bn;
    bit ch;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      x = W'($urandom); y = W'($urandom); c = 1'($urandom); s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`endif
      e = model(x, y, c, s);
      launch(x, y, c, s);
      wait_done(lat, bn, ch);
      checks++; if (lat !== 9) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want 9", i, lat); end
      checks++; if (sum !== e[W-1:0]) begin errors++; $display("FAIL rnd_sum[%0d]: %h op %h c%b s%b got %h want %h", i, x, y, c, s, sum, e[W-1:0]); end
      checks++; if (cout !== e[W]) begin errors++; $display("FAIL rnd_cout[%0d]: got %b want %b", i, cout, e[W]); end
`ifdef SERIAL_ADDER_SUB_EN
      checks++; if (ovf !== e[W+1]) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, ovf, e[W+1]); end
`endif
    end
    tick;
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int lat, bn;
    bit ch;
    launch(8'h05, 8'h07, 1'b0, 1'b1);
    wait_done(lat, bn, ch);
    checks++; if (sum !== 8'hFE) begin errors++; $display("FAIL sub1_sum: got %h want fe", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub1_cout: got %b want 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub1_ovf: got %b want 0", ovf); end
    tick;
    launch(8'h80, 8'h01, 1'b1, 1'b1);
    wait_done(lat, bn, ch);
    checks++; if (sum !== 8'h7F) begin errors++; $display("FAIL sub2_sum: got %h want 7f", sum); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sub2_ovf: got %b want 1", ovf); end
    tick;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
    test_random;
`ifdef SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
